// File: rtl/fifo_led_prefetch_sync.sv
// Single-clock first-word-fall-through FIFO with a block-RAM store and 2-entry prefetch stage.
// Optional synchronous flush port is enabled by defining FIFO_LED_SYNC_FLUSH_EN.
module fifo_led_prefetch_sync #(
    parameter int DATA_WIDTH  = 8,
    parameter int DEPTH_WIDTH = 10,
    parameter int AF_LEVEL    = 1020,
    parameter int AE_LEVEL    = 4
) (
    input  logic                   clk,
    input  logic                   rst,
`ifdef FIFO_LED_SYNC_FLUSH_EN
    input  logic                   flush,
`endif
    input  logic                   wr_en,
    input  logic [DATA_WIDTH-1:0]  wr_data,
    output logic                   wr_vld,
    input  logic                   rd_en,
    output logic [DATA_WIDTH-1:0]  rd_data,
    output logic                   rd_vld,
    output logic [DEPTH_WIDTH:0]   level,
    output logic                   almost_full,
    output logic                   almost_empty,
    output logic                   wr_ovf,
    output logic                   rd_unf
);
    localparam int LW = DEPTH_WIDTH + 1;
    localparam int DEPTH = 1 << DEPTH_WIDTH;
    localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);
    localparam logic [LW-1:0] AF_L = LW'(AF_LEVEL);
    localparam logic [LW-1:0] AE_L = LW'(AE_LEVEL);
    localparam logic [LW-1:0] ONE_L = LW'(1);
    localparam logic [DEPTH_WIDTH-1:0] ONE_P = DEPTH_WIDTH'(1);

    logic flush_i;
`ifdef FIFO_LED_SYNC_FLUSH_EN
    assign flush_i = flush;
`else
    assign flush_i = 1'b0;
`endif

    logic [DATA_WIDTH-1:0]  mem [DEPTH];
    logic [DATA_WIDTH-1:0]  ram_rdata;

    logic [DEPTH_WIDTH-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]          ram_cnt_q, ram_cnt_d;
    logic [LW-1:0]          level_q, level_d;
    logic                   pend_q, pend_d;
    logic [1:0]             ob_cnt_q, ob_cnt_d, ob_next;
    logic [DATA_WIDTH-1:0]  head_q, head_d, skid_q, skid_d;
    logic                   wr_vld_q, wr_vld_d;
    logic                   af_q, af_d, ae_q, ae_d;
    logic                   ovf_q, ovf_d, unf_q, unf_d;
    logic                   wr_acc, rd_pop, issue;

    always_comb begin
        wr_acc   = wr_en && wr_vld_q && !flush_i;
        rd_pop   = rd_en && (ob_cnt_q != 2'd0) && !flush_i;
        ob_next  = ob_cnt_q + {1'b0, pend_q} - {1'b0, rd_pop};
        // A read issued now lands next edge, so only issue if the buffer will still have a free slot.
        issue    = (ram_cnt_q != '0) && (ob_next != 2'd2) && !flush_i;

        wr_ptr_d  = wr_acc ? wr_ptr_q + ONE_P : wr_ptr_q;
        rd_ptr_d  = issue ? rd_ptr_q + ONE_P : rd_ptr_q;
        ram_cnt_d = ram_cnt_q;
        if (wr_acc && !issue) ram_cnt_d = ram_cnt_q + ONE_L;
        else if (!wr_acc && issue) ram_cnt_d = ram_cnt_q - ONE_L;
        level_d = level_q;
        if (wr_acc && !rd_pop) level_d = level_q + ONE_L;
        else if (!wr_acc && rd_pop) level_d = level_q - ONE_L;
        pend_d   = issue;
        ob_cnt_d = ob_next;

        head_d = head_q;
        skid_d = skid_q;
        if (pend_q) begin
            if (ob_cnt_q == 2'd0 || (ob_cnt_q == 2'd1 && rd_pop)) begin
                head_d = ram_rdata;
            end else if (ob_cnt_q == 2'd1) begin
                skid_d = ram_rdata;
            end else begin
                head_d = skid_q;
                skid_d = ram_rdata;
            end
        end else if (rd_pop && ob_cnt_q == 2'd2) begin
            head_d = skid_q;
        end

        ovf_d = wr_en && !wr_vld_q && !flush_i;
        unf_d = rd_en && (ob_cnt_q == 2'd0) && !flush_i;

        if (flush_i) begin
            wr_ptr_d  = '0;
            rd_ptr_d  = '0;
            ram_cnt_d = '0;
            level_d   = '0;
            pend_d    = 1'b0;
            ob_cnt_d  = 2'd0;
        end

        wr_vld_d = level_d < DEPTH_L;
        af_d     = level_d >= AF_L;
        ae_d     = level_d <= AE_L;
    end

    // Storage has no reset so it maps onto block RAM; pend_q qualifies ram_rdata.
    always_ff @(posedge clk) begin
        if (wr_acc) mem[wr_ptr_q] <= wr_data;
        if (issue) ram_rdata <= mem[rd_ptr_q];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            ram_cnt_q <= '0;
            level_q   <= '0;
            pend_q    <= 1'b0;
            ob_cnt_q  <= 2'd0;
            head_q    <= '0;
            skid_q    <= '0;
            wr_vld_q  <= 1'b1;
            af_q      <= 1'b0;
            ae_q      <= 1'b1;
            ovf_q     <= 1'b0;
            unf_q     <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            ram_cnt_q <= ram_cnt_d;
            level_q   <= level_d;
            pend_q    <= pend_d;
            ob_cnt_q  <= ob_cnt_d;
            head_q    <= head_d;
            skid_q    <= skid_d;
            wr_vld_q  <= wr_vld_d;
            af_q      <= af_d;
            ae_q      <= ae_d;
            ovf_q     <= ovf_d;
            unf_q     <= unf_d;
        end
    end

    assign wr_vld       = wr_vld_q;
    assign rd_data      = head_q;
    assign rd_vld       = (ob_cnt_q != 2'd0);
    assign level        = level_q;
    assign almost_full  = af_q;
    assign almost_empty = ae_q;
    assign wr_ovf       = ovf_q;
    assign rd_unf       = unf_q;
endmodule

// File: tb/tb_fifo_led_prefetch_sync.sv
// Directed self-checking bench for fifo_led_prefetch_sync against a queue scoreboard.
// Flush steps run only when FIFO_LED_SYNC_FLUSH_EN is defined.
module tb_fifo_led_prefetch_sync;
    localparam int DEPTH = 1024;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_en, rd_en;
    logic [7:0]  wr_data;
    logic        wr_vld, rd_vld, almost_full, almost_empty, wr_ovf, rd_unf;
    logic [7:0]  rd_data;
    logic [10:0] level;
`ifdef FIFO_LED_SYNC_FLUSH_EN
    logic        flush;
`endif

    int         n_checks = 0;
    int         n_fail = 0;
    logic [7:0] sb[$];
    int         m_count = 0;
    logic       m_ovf = 1'b0;
    logic       m_unf = 1'b0;

    always #5 clk = ~clk;

    fifo_led_prefetch_sync #(
        .DATA_WIDTH(8), .DEPTH_WIDTH(10), .AF_LEVEL(1020), .AE_LEVEL(4)
    ) dut (
        .clk(clk),
        .rst(rst),
`ifdef FIFO_LED_SYNC_FLUSH_EN
        .flush(flush),
`endif
        .wr_en(wr_en),
        .wr_data(wr_data),
        .wr_vld(wr_vld),
        .rd_en(rd_en),
        .rd_data(rd_data),
        .rd_vld(rd_vld),
        .level(level),
        .almost_full(almost_full),
        .almost_empty(almost_empty),
        .wr_ovf(wr_ovf),
        .rd_unf(rd_unf)
    );

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Compare every output against the scoreboard after an edge.
    task automatic checkModel();
        checkOutput("level", 32'(level), 32'(m_count));
        checkOutput("wr_vld", 32'(wr_vld), 32'(m_count < DEPTH));
        checkOutput("almost_full", 32'(almost_full), 32'(m_count >= 1020));
        checkOutput("almost_empty", 32'(almost_empty), 32'(m_count <= 4));
        checkOutput("wr_ovf", 32'(wr_ovf), 32'(m_ovf));
        checkOutput("rd_unf", 32'(rd_unf), 32'(m_unf));
        if (m_count == 0) checkOutput("rd_vld_empty", 32'(rd_vld), 32'(0));
        if (rd_vld === 1'b1 && sb.size() > 0) checkOutput("rd_data_head", 32'(rd_data), 32'(sb[0]));
    endtask

    task automatic applyStimulus(input logic we, input logic [7:0] wd, input logic re, input logic fl);
        logic       pre_vld;
        logic [7:0] pre_data;
        logic       room;
        wr_en = we;
        wr_data = wd;
        rd_en = re;
`ifdef FIFO_LED_SYNC_FLUSH_EN
        flush = fl;
`endif
        pre_vld = rd_vld;
        pre_data = rd_data;
        @(posedge clk);
        if (fl) begin
            sb.delete();
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end else begin
            room = (sb.size() < DEPTH);
            m_ovf = we && !room;
            m_unf = re && !pre_vld;
            if (re && pre_vld) begin
                if (sb.size() == 0) begin
                    checkOutput("pop_nonempty", 32'(sb.size()), 32'(1));
                end else begin
                    checkOutput("pop_data", 32'(pre_data), 32'(sb[0]));
                    void'(sb.pop_front());
                end
            end
            if (we && room) sb.push_back(wd);
        end
        m_count = sb.size();
        #1;
        checkModel();
    endtask

    initial begin
        logic [7:0] cnt;
        logic [7:0] rnd;
        int         unf_seen;
        rst = 1'b1;
        wr_en = 1'b0;
        rd_en = 1'b0;
        wr_data = '0;
`ifdef FIFO_LED_SYNC_FLUSH_EN
        flush = 1'b0;
`endif
        #2;
        checkOutput("rst_wr_vld", 32'(wr_vld), 32'(1));
        checkOutput("rst_rd_vld", 32'(rd_vld), 32'(0));
        checkOutput("rst_rd_data", 32'(rd_data), 32'(0));
        checkOutput("rst_level", 32'(level), 32'(0));
        checkOutput("rst_af", 32'(almost_full), 32'(0));
        checkOutput("rst_ae", 32'(almost_empty), 32'(1));
        checkOutput("rst_ovf", 32'(wr_ovf), 32'(0));
        checkOutput("rst_unf", 32'(rd_unf), 32'(0));
        #1 rst = 1'b0;

        $display("[TB] single write latency");
        applyStimulus(1'b1, 8'hA5, 1'b0, 1'b0);
        checkOutput("lat_level_e1", 32'(level), 32'(1));
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
        checkOutput("lat_rd_vld_e2", 32'(rd_vld), 32'(0));
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
        checkOutput("lat_rd_vld_e3", 32'(rd_vld), 32'(1));
        checkOutput("lat_rd_data_e3", 32'(rd_data), 32'(8'hA5));
        checkOutput("lat_ae", 32'(almost_empty), 32'(1));
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);

        $display("[TB] fill to full");
        cnt = 8'h00;
        for (int i = 0; i < DEPTH; i++) begin
            applyStimulus(1'b1, cnt, 1'b0, 1'b0);
            cnt = cnt + 8'd1;
        end
        checkOutput("full_wr_vld", 32'(wr_vld), 32'(0));
        checkOutput("full_level", 32'(level), 32'(1024));
        checkOutput("full_af", 32'(almost_full), 32'(1));
        applyStimulus(1'b1, 8'hEE, 1'b0, 1'b0);
        checkOutput("full_ovf", 32'(wr_ovf), 32'(1));
        checkOutput("full_level_hold", 32'(level), 32'(1024));

        $display("[TB] sustained write+read from full");
        for (int i = 0; i < 2000; i++) begin
            applyStimulus(1'b1, cnt, 1'b1, 1'b0);
            if (sb.size() == m_count && m_count < DEPTH) cnt = cnt + 8'd1;
            checkOutput("stream_rd_vld", 32'(rd_vld), 32'(1));
        end

        $display("[TB] drain and underflow");
        for (int i = 0; i < 1200 && (m_count > 0 || rd_vld === 1'b1); i++) begin
            applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        end
        checkOutput("drain_level", 32'(level), 32'(0));
        unf_seen = 0;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
            if (rd_unf === 1'b1) unf_seen++;
            checkOutput("unf_rd_vld", 32'(rd_vld), 32'(0));
        end
        checkOutput("unf_pulses", 32'(unf_seen), 32'(3));

        $display("[TB] random traffic");
        for (int i = 0; i < 10000; i++) begin
            rnd = 8'($urandom);
            applyStimulus(1'($urandom_range(0, 1)), rnd, 1'($urandom_range(0, 1)), 1'b0);
        end

        $display("[TB] reset mid-operation");
        for (int i = 0; i < 6; i++) applyStimulus(1'b1, 8'(i + 8'h40), 1'b0, 1'b0);
        rst = 1'b1;
        #1;
        checkOutput("mrst_level", 32'(level), 32'(0));
        checkOutput("mrst_rd_vld", 32'(rd_vld), 32'(0));
        checkOutput("mrst_rd_data", 32'(rd_data), 32'(0));
        checkOutput("mrst_wr_vld", 32'(wr_vld), 32'(1));
        sb.delete();
        m_count = 0;
        m_ovf = 1'b0;
        m_unf = 1'b0;
        #1 rst = 1'b0;
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
        applyStimulus(1'b1, 8'h77, 1'b0, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
        checkOutput("mrst_after_data", 32'(rd_data), 32'(8'h77));
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);

`ifdef FIFO_LED_SYNC_FLUSH_EN
        $display("[TB] flush");
        for (int i = 0; i < 600; i++) applyStimulus(1'b1, 8'(i), 1'b0, 1'b0);
        checkOutput("pre_flush_level", 32'(level), 32'(600));
        applyStimulus(1'b1, 8'h99, 1'b1, 1'b1);
        checkOutput("flush_level", 32'(level), 32'(0));
        checkOutput("flush_rd_vld", 32'(rd_vld), 32'(0));
        checkOutput("flush_ovf", 32'(wr_ovf), 32'(0));
        applyStimulus(1'b1, 8'h3C, 1'b0, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
        checkOutput("flush_after_vld", 32'(rd_vld), 32'(1));
        checkOutput("flush_after_data", 32'(rd_data), 32'(8'h3C));
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
